fpmac_dot_ctrl: RTL

Sequencer that streams FP16 operand pairs through one FPMAC datapath instance and produces a dot product, a·b summed over the vector plus an initial value. It owns the accumulator register, which feeds the MAC's addend input. It uses valid/ready handshakes on the operand stream and on the result. It sits between the operand fetch logic and the writeback path and gives the combinational FPMAC its only sequential context.

---
 rtl/fpmac_pkg.sv | 42 ++++
 rtl/FPMAC.sv | 118 +++++++++++
 rtl/fpmac_dot_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/fpmac_pkg.sv
// Shared types, FP16 constants and field helpers for the dot-product sequencer
// and its FPMAC datapath.
package fpmac_pkg;

    localparam int unsigned FP_W  = 16;
    localparam int unsigned SIG_W = 11;
    localparam int unsigned EXP_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [EXP_W-1:0] EXP_ALL_ONES = 5'h1F;
    localparam logic [FP_W-1:0]  POS_INF      = 16'h7C00;
    localparam logic [FP_W-1:0]  ZERO         = 16'h0000;
    localparam logic [FP_W-1:0]  QNAN         = 16'h7E00;

    function automatic logic fp16_is_nan(input logic [FP_W-1:0] x);
        return (x[14:10] == EXP_ALL_ONES) && (x[9:0] != 10'd0);
    endfunction

    function automatic logic fp16_is_inf(input logic [FP_W-1:0] x);
        return (x[14:10] == EXP_ALL_ONES) && (x[9:0] == 10'd0);
    endfunction

    function automatic logic fp16_is_zero(input logic [FP_W-1:0] x);
        return x[14:0] == 15'd0;
    endfunction

    // Significand with the hidden bit made explicit (0 for subnormals).
    function automatic logic [SIG_W-1:0] fp16_sig(input logic [FP_W-1:0] x);
        return {|x[14:10], x[9:0]};
    endfunction

    // Subnormals share the scale of exponent field 1.
    function automatic logic [EXP_W-1:0] fp16_exp_eff(input logic [FP_W-1:0] x);
        return (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
    endfunction

endpackage

// File: rtl/FPMAC.sv
// Combinational FP16 fused multiply-add: o_result = a*b + c (or a*b - c),
// single round-to-nearest-even on the exact sum.
module FPMAC
    import fpmac_pkg::*;
(
    input  logic [FP_W-1:0] i_a,
    input  logic [FP_W-1:0] i_b,
    input  logic [FP_W-1:0] i_c,
    input  logic            i_sub,
    output logic [FP_W-1:0] o_result
);

    // LSB weight 2^-48 holds the smallest subnormal product exactly.
    localparam int unsigned SUM_W = 82;
    localparam int unsigned POS_W = 7;

    logic             sp;
    logic             sc;
    logic [21:0]      prod;
    logic [5:0]       sh_p;
    logic [5:0]       sh_c;
    logic [SUM_W-1:0] pmag;
    logic [SUM_W-1:0] cmag;
    logic [SUM_W-1:0] mag;
    logic [SUM_W-1:0] gmask;
    logic             rs;
    logic [POS_W-1:0] lead;
    logic [POS_W-1:0] lsb;
    logic [10:0]      q;
    logic [11:0]      qr;
    logic             guard;
    logic             sticky;
    logic [7:0]       e_res;
    logic [FP_W-1:0]  fin;
    logic             a_inf;
    logic             b_inf;
    logic             c_inf;
    logic             p_inf;
    logic             nan_in;
    logic             invalid;

    assign sp   = i_a[15] ^ i_b[15];
    assign sc   = i_c[15] ^ i_sub;
    assign prod = 22'(fp16_sig(i_a)) * 22'(fp16_sig(i_b));
    assign sh_p = 6'(fp16_exp_eff(i_a)) + 6'(fp16_exp_eff(i_b)) - 6'd2;
    assign sh_c = 6'(fp16_exp_eff(i_c)) + 6'd23;
    assign pmag = SUM_W'(prod) << sh_p;
    assign cmag = SUM_W'(fp16_sig(i_c)) << sh_c;

    // Signed-magnitude exact sum; exact cancellation gives +0 unless both terms are negative.
    always_comb begin
        mag = '0;
        rs  = 1'b0;
        if (sp == sc) begin
            mag = pmag + cmag;
            rs  = sp;
        end else if (pmag >= cmag) begin
            mag = pmag - cmag;
            rs  = sp;
        end else begin
            mag = cmag - pmag;
            rs  = sc;
        end
        if (mag == '0) begin
            rs = sp & sc;
        end
    end

    always_comb begin
        lead = '0;
        for (int i = 0; i < SUM_W; i++) begin
            if (mag[i]) begin
                lead = POS_W'(i);
            end
        end
    end

    // Keep 11 significant bits, but never below the subnormal quantum (bit 24).
    always_comb begin
        lsb    = (lead >= POS_W'(34)) ? lead - POS_W'(10) : POS_W'(24);
        q      = 11'(mag >> lsb);
        gmask  = SUM_W'(1) << (lsb - POS_W'(1));
        guard  = |(mag & gmask);
        sticky = |(mag & (gmask - SUM_W'(1)));
        qr     = {1'b0, q} + 12'(guard & (sticky | q[0]));
        e_res  = 8'd0;
        if (qr[11]) begin
            e_res = {1'b0, lsb} - 8'd22;
        end else if (qr[10]) begin
            e_res = {1'b0, lsb} - 8'd23;
        end
        if (e_res >= 8'd31) begin
            fin = {rs, POS_INF[14:0]};
        end else begin
            fin = {rs, e_res[4:0], qr[9:0]};
        end
    end

    assign a_inf   = fp16_is_inf(i_a);
    assign b_inf   = fp16_is_inf(i_b);
    assign c_inf   = fp16_is_inf(i_c);
    assign p_inf   = a_inf | b_inf;
    assign nan_in  = fp16_is_nan(i_a) | fp16_is_nan(i_b) | fp16_is_nan(i_c);
    assign invalid = (a_inf & fp16_is_zero(i_b)) | (b_inf & fp16_is_zero(i_a)) |
                     (p_inf & c_inf & (sp != sc));

    always_comb begin
        o_result = fin;
        if (nan_in || invalid) begin
            o_result = QNAN;
        end else if (p_inf) begin
            o_result = {sp, POS_INF[14:0]};
        end else if (c_inf) begin
            o_result = {sc, POS_INF[14:0]};
        end
    end

endmodule

// File: rtl/fpmac_dot_ctrl.sv
// Dot-product sequencer: streams operand pairs through one FPMAC, owns the
// accumulator and presents the final sum with sticky NaN/Inf flags.
module fpmac_dot_ctrl
    import fpmac_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic [FP_W-1:0]  i_init,
    input  logic             i_abort,
    input  logic [FP_W-1:0]  i_a,
    input  logic [FP_W-1:0]  i_b,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_busy,
    output logic [FP_W-1:0]  o_result,
    output logic             o_result_valid,
    input  logic             i_result_ready,
    output logic             o_nan,
    output logic             o_inf
);

    state_t           state;
    logic [FP_W-1:0]  acc;
    logic [LEN_W-1:0] cnt;
    logic [FP_W-1:0]  mac_out;
    logic             beat;

    FPMAC u_fpmac (
        .i_a      (i_a),
        .i_b      (i_b),
        .i_c      (acc),
        .i_sub    (1'b0),
        .o_result (mac_out)
    );

    // o_ready is high exactly in RUN, so it doubles as the state decode here.
    assign beat     = i_valid && o_ready;
    assign o_result = acc;

    // Status outputs are loaded together with the state so they stay pure register decodes.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state          <= ST_IDLE;
            acc            <= ZERO;
            cnt            <= '0;
            o_ready        <= 1'b0;
            o_busy         <= 1'b0;
            o_result_valid <= 1'b0;
            o_nan          <= 1'b0;
            o_inf          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        acc    <= i_init;
                        cnt    <= i_len;
                        o_nan  <= 1'b0;
                        o_inf  <= 1'b0;
                        o_busy <= 1'b1;
                        if (i_len != '0) begin
                            state   <= ST_RUN;
                            o_ready <= 1'b1;
                        end else begin
                            state          <= ST_DONE;
                            o_result_valid <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_abort) begin
                        state   <= ST_IDLE;
                        o_ready <= 1'b0;
                        o_busy  <= 1'b0;
                    end else if (beat) begin
                        acc   <= mac_out;
                        cnt   <= cnt - LEN_W'(1);
                        o_nan <= o_nan | fp16_is_nan(mac_out);
                        o_inf <= o_inf | fp16_is_inf(mac_out);
                        if (cnt == LEN_W'(1)) begin
                            state          <= ST_DONE;
                            o_ready        <= 1'b0;
                            o_result_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (i_abort || i_result_ready) begin
                        state          <= ST_IDLE;
                        o_busy         <= 1'b0;
                        o_result_valid <= 1'b0;
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    o_ready        <= 1'b0;
                    o_busy         <= 1'b0;
                    o_result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
